// File: rtl/uart_top.sv
// uart_top: CPU-register-mapped UART with a one-deep TX holding register and a 2-flop RX synchronizer.
// Default frame is 8N1; defining UART_PARITY_EN adds an even-parity bit on both TX and RX.
module uart_top #(
  parameter int ADDR_LSB          = 0,
  parameter int OPT_MEM_ADDR_BITS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] addr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  input  logic       wr_en,
  input  logic       rd_en,
  output logic       tx,
  input  logic       rx
);
  localparam int SEL_W = OPT_MEM_ADDR_BITS + 1;
  localparam logic [SEL_W-1:0] SEL_DATA = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_STAT = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_DIVL = SEL_W'(2);
  localparam logic [SEL_W-1:0] SEL_DIVH = SEL_W'(3);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_STOP   = 3'd4;
`ifdef UART_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif

  logic [SEL_W-1:0] sel;
  logic             wr_data, rd_data, rd_stat;
  logic [15:0]      div;
  logic             unused_addr;

  logic [2:0]  tx_state;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_idx;
  logic [7:0]  tx_hold, tx_shift;
  logic        tx_full, tx_busy, tx_tick, tx_par;

  logic        sync1, sync2, rx_prev;
  logic [2:0]  rx_state;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_idx;
  logic [7:0]  rx_shift, rx_data;
  logic        rx_tick, rx_valid, rx_overrun, rx_frame_err, rx_parity_err;

  assign sel         = addr[ADDR_LSB+OPT_MEM_ADDR_BITS:ADDR_LSB];
  assign unused_addr = ^addr;
  assign wr_data     = wr_en && (sel == SEL_DATA);
  assign rd_data     = rd_en && (sel == SEL_DATA);
  assign rd_stat     = rd_en && (sel == SEL_STAT);
  assign tx_tick     = (tx_cnt == '0);
  assign rx_tick     = (rx_cnt == '0);
  assign tx_busy     = (tx_state != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div <= 16'd867;
    end else if (wr_en && sel == SEL_DIVL) begin
      div[7:0] <= din;
    end else if (wr_en && sel == SEL_DIVH) begin
      div[15:8] <= din;
    end
  end

  // Bit timers reload from div at each bit boundary, so divisor writes apply to the next bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_hold  <= '0;
      tx_shift <= '0;
      tx_full  <= 1'b0;
      tx_par   <= 1'b0;
    end else begin
      if (wr_data && !tx_full) begin
        tx_hold <= din;
        tx_full <= 1'b1;
      end
      if (!tx_tick) tx_cnt <= tx_cnt - 16'd1;
      case (tx_state)
        ST_IDLE: if (tx_full) begin
          tx_state <= ST_START;
          tx_shift <= tx_hold;
          tx_par   <= ^tx_hold;
          tx_full  <= 1'b0;
          tx_cnt   <= div;
        end
        ST_START: if (tx_tick) begin
          tx_state <= ST_DATA;
          tx_idx   <= '0;
          tx_cnt   <= div;
        end
        ST_DATA: if (tx_tick) begin
          tx_shift <= {1'b0, tx_shift[7:1]};
          tx_idx   <= tx_idx + 3'd1;
          tx_cnt   <= div;
          if (tx_idx == 3'd7) begin
`ifdef UART_PARITY_EN
            tx_state <= ST_PARITY;
`else
            tx_state <= ST_STOP;
`endif
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: if (tx_tick) begin
          tx_state <= ST_STOP;
          tx_cnt   <= div;
        end
`endif
        ST_STOP: if (tx_tick) begin
          if (tx_full) begin
            tx_state <= ST_START;
            tx_shift <= tx_hold;
            tx_par   <= ^tx_hold;
            tx_full  <= 1'b0;
            tx_cnt   <= div;
          end else begin
            tx_state <= ST_IDLE;
          end
        end
        default: tx_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    tx = 1'b1;
    case (tx_state)
      ST_START:  tx = 1'b0;
      ST_DATA:   tx = tx_shift[0];
`ifdef UART_PARITY_EN
      ST_PARITY: tx = tx_par;
`endif
      default:   tx = 1'b1;
    endcase
  end

`ifndef UART_PARITY_EN
  assign rx_parity_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1        <= 1'b1;
      sync2        <= 1'b1;
      rx_prev      <= 1'b1;
      rx_state     <= ST_IDLE;
      rx_cnt       <= '0;
      rx_idx       <= '0;
      rx_shift     <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_overrun   <= 1'b0;
      rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
      rx_parity_err <= 1'b0;
`endif
    end else begin
      sync1   <= rx;
      sync2   <= sync1;
      rx_prev <= sync2;
      // Read-clears come first so that a set event later in this block wins.
      if (rd_data) rx_valid <= 1'b0;
      if (rd_stat) begin
        rx_overrun   <= 1'b0;
        rx_frame_err <= 1'b0;
`ifdef UART_PARITY_EN
        rx_parity_err <= 1'b0;
`endif
      end
      if (!rx_tick) rx_cnt <= rx_cnt - 16'd1;
      case (rx_state)
        ST_IDLE: if (rx_prev && !sync2) begin
          rx_state <= ST_START;
          rx_cnt   <= {1'b0, div[15:1]};
        end
        ST_START: if (rx_tick) begin
          if (sync2) begin
            rx_state <= ST_IDLE;
          end else begin
            rx_state <= ST_DATA;
            rx_idx   <= '0;
            rx_cnt   <= div;
          end
        end
        ST_DATA: if (rx_tick) begin
          rx_shift <= {sync2, rx_shift[7:1]};
          rx_idx   <= rx_idx + 3'd1;
          rx_cnt   <= div;
          if (rx_idx == 3'd7) begin
`ifdef UART_PARITY_EN
            rx_state <= ST_PARITY;
`else
            rx_state <= ST_STOP;
`endif
          end
        end
`ifdef UART_PARITY_EN
        ST_PARITY: if (rx_tick) begin
          if (sync2 != ^rx_shift) rx_parity_err <= 1'b1;
          rx_state <= ST_STOP;
          rx_cnt   <= div;
        end
`endif
        ST_STOP: if (rx_tick) begin
          rx_state <= ST_IDLE;
          if (!sync2) rx_frame_err <= 1'b1;
          if (!rx_valid || rd_data) begin
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
          end else begin
            rx_overrun <= 1'b1;
          end
        end
        default: rx_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    dout = '0;
    case (sel)
      SEL_DATA: dout = rx_data;
      SEL_STAT: dout = {2'b00, rx_parity_err, rx_frame_err, rx_overrun, rx_valid, tx_full, tx_busy};
      SEL_DIVL: dout = div[7:0];
      SEL_DIVH: dout = div[15:8];
      default:  dout = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_top.sv
// Bench for uart_top: register vector table, directed TX/RX frame sequences and a randomized RX/TX
// run checked against a register-level model plus a tx line decoder.
module tb_uart_top;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] addr, din, dout;
  logic       wr_en, rd_en, tx, rx;

  always #5 clk = ~clk;

  uart_top #(.ADDR_LSB(0), .OPT_MEM_ADDR_BITS(1)) dut (
    .clk(clk), .reset(reset), .addr(addr), .din(din), .dout(dout),
    .wr_en(wr_en), .rd_en(rd_en), .tx(tx), .rx(rx)
  );

`ifdef UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  typedef struct {
    logic [7:0] a;
    logic       wr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } reg_vec_t;

  int         vectors = 0;
  int         miscompares = 0;
  int         cyc = 0;
  int         bitlen = 868;
  logic [7:0] txq[$];
  int         txt[$];

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b);
    logic [10:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef UART_PARITY_EN
    f[9]   = ^b;
`endif
    return f;
  endfunction

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; din = d; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    addr = a; rd_en = 1'b1;
    #1 d = dout;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic set_div(input logic [15:0] d);
    bus_write(8'h02, d[7:0]);
    bus_write(8'h03, d[15:8]);
    bitlen = int'(d) + 1;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop_ok, input int bl);
    logic [10:0] fb;
    fb = frame_bits(b);
    if (!stop_ok) fb[NBITS-1] = 1'b0;
    for (int j = 0; j < NBITS; j++) begin
      @(negedge clk);
      rx = fb[j];
      repeat (bl - 1) @(negedge clk);
    end
    @(negedge clk);
    rx = 1'b1;
    repeat (2 * bl) @(negedge clk);
  endtask

  task automatic wait_txq(input int n, input int limit);
    int i;
    i = 0;
    while (txq.size() < n && i < limit) begin
      @(negedge clk);
      i++;
    end
    if (txq.size() < n) check("tx_frame_timeout", 64'(txq.size()), 64'(n));
  endtask

  // Line decoder: samples each bit at its centre, bit period taken from bitlen.
  initial begin : tx_mon
    logic       prev;
    logic [7:0] b;
    int         t0;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev && tx === 1'b0) begin
        t0 = cyc;
        repeat (bitlen + bitlen / 2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          b[k] = tx;
          if (k < 7) repeat (bitlen) @(negedge clk);
        end
        repeat (bitlen * (NBITS - 9)) @(negedge clk);
        txq.push_back(b);
        txt.push_back(t0);
      end
      prev = tx;
    end
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    reg_vec_t    vecs[8];
    logic [7:0]  s;
    logic [63:0] cap_tx, cap_busy, exp_tx;
    logic [10:0] fb;
    logic [7:0]  m_data, b;
    logic        m_valid, m_ovr, m_ferr, stop_ok;

    reset = 1'b1; rx = 1'b1; wr_en = 1'b0; rd_en = 1'b0; addr = 8'h01; din = 8'h00;
    #1;
    check("reset_tx", 64'(tx), 64'(1));
    check("reset_status", 64'(dout), 64'h00);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    bus_read(8'h02, s); check("reset_divl", 64'(s), 64'h63);
    bus_read(8'h03, s); check("reset_divh", 64'(s), 64'h03);
    bus_read(8'h00, s); check("reset_rxdata", 64'(s), 64'h00);

    vecs[0] = '{8'h02, 1'b1, 8'h34, 8'h34};
    vecs[1] = '{8'h03, 1'b1, 8'h12, 8'h12};
    vecs[2] = '{8'h02, 1'b0, 8'h00, 8'h34};
    vecs[3] = '{8'hF1, 1'b1, 8'hFF, 8'h00};
    vecs[4] = '{8'h06, 1'b1, 8'hA0, 8'hA0};
    vecs[5] = '{8'h07, 1'b0, 8'h00, 8'h12};
    vecs[6] = '{8'h00, 1'b0, 8'h00, 8'h00};
    vecs[7] = '{8'h02, 1'b0, 8'h00, 8'hA0};
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].a, vecs[i].wdata);
      bus_read(vecs[i].a, s);
      check($sformatf("regvec%0d", i), 64'(s), 64'(vecs[i].exp));
    end

    // Single byte 0x55 at divisor 3: exact waveform and busy window.
    set_div(16'd3);
    bus_write(8'h00, 8'h55);
    addr = 8'h01;
    check("tx_idle_before_start", 64'({tx, dout[0]}), 64'b10);
    cap_tx = '0; cap_busy = '0; exp_tx = '0;
    fb = frame_bits(8'h55);
    for (int i = 0; i < NBITS * 4; i++) begin
      @(negedge clk);
      cap_tx[i]   = tx;
      cap_busy[i] = dout[0];
      exp_tx[i]   = fb[i / 4];
    end
    check("tx55_wave", cap_tx, exp_tx);
    check("tx55_busy", cap_busy, (64'd1 << (NBITS * 4)) - 64'd1);
    @(negedge clk);
    check("tx55_after", 64'({tx, dout[0]}), 64'b10);
    wait_txq(1, 20);
    txq.delete(); txt.delete();

    // Back-to-back bytes, third write while tx_full must be dropped.
    bus_write(8'h00, 8'hA5);
    for (int i = 0; i < 20; i++) begin
      bus_read(8'h01, s);
      if (!s[1]) break;
    end
    check("txfull_cleared", 64'(s[1]), 64'(0));
    bus_write(8'h00, 8'h3C);
    bus_write(8'h00, 8'h99);
    bus_read(8'h01, s); check("tx_full_third", 64'(s), 64'h03);
    wait_txq(2, 200);
    repeat (80) @(negedge clk);
    check("b2b_count", 64'(txq.size()), 64'(2));
    if (txq.size() == 2) begin
      check("b2b_first", 64'(txq[0]), 64'hA5);
      check("b2b_second", 64'(txq[1]), 64'h3C);
      check("b2b_gap", 64'(txt[1] - txt[0]), 64'(NBITS * 4));
    end
    bus_read(8'h01, s); check("b2b_idle_status", 64'(s), 64'h00);
    txq.delete(); txt.delete();

    // RX basic, overrun, frame error and glitch at divisor 7.
    set_div(16'd7);
    send_rx(8'hC3, 1'b1, bitlen);
    bus_read(8'h01, s); check("rx_c3_status", 64'(s), 64'h04);
    bus_read(8'h00, s); check("rx_c3_data", 64'(s), 64'hC3);
    bus_read(8'h01, s); check("rx_c3_cleared", 64'(s), 64'h00);

    send_rx(8'h11, 1'b1, bitlen);
    send_rx(8'h22, 1'b1, bitlen);
    bus_read(8'h01, s); check("ovr_status1", 64'(s), 64'h0C);
    bus_read(8'h01, s); check("ovr_status2", 64'(s), 64'h04);
    bus_read(8'h00, s); check("ovr_data", 64'(s), 64'h11);
    bus_read(8'h01, s); check("ovr_status3", 64'(s), 64'h00);

    send_rx(8'h7E, 1'b0, bitlen);
    bus_read(8'h01, s); check("ferr_status", 64'(s), 64'h14);
    bus_read(8'h00, s); check("ferr_data", 64'(s), 64'h7E);
    bus_read(8'h01, s); check("ferr_cleared", 64'(s), 64'h00);
    @(negedge clk); rx = 1'b0;
    @(negedge clk); rx = 1'b1;
    repeat (3 * bitlen) @(negedge clk);
    bus_read(8'h01, s); check("glitch_status", 64'(s), 64'h00);
    send_rx(8'h5A, 1'b1, bitlen);
    bus_read(8'h01, s); check("post_glitch_status", 64'(s), 64'h04);
    bus_read(8'h00, s); check("post_glitch_data", 64'(s), 64'h5A);

    // Randomized run against the register-level model.
    m_data = 8'h5A; m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
    for (int it = 0; it < 12; it++) begin
      set_div(16'($urandom_range(2, 9)));
      b       = 8'($urandom);
      stop_ok = ($urandom_range(0, 3) != 0);
      send_rx(b, stop_ok, bitlen);
      if (!stop_ok) m_ferr = 1'b1;
      if (!m_valid) begin
        m_data  = b;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
      case ($urandom_range(0, 2))
        1: begin
          bus_read(8'h01, s);
          check($sformatf("rand%0d_status", it), 64'(s), 64'({4'b0000, m_ferr, m_ovr, m_valid, 2'b00}));
          m_ovr = 1'b0; m_ferr = 1'b0;
        end
        2: begin
          bus_read(8'h00, s);
          check($sformatf("rand%0d_data", it), 64'(s), 64'(m_data));
          m_valid = 1'b0;
        end
        default: ;
      endcase
      b = 8'($urandom);
      bus_write(8'h00, b);
      wait_txq(1, 20 * bitlen);
      if (txq.size() > 0) check($sformatf("rand%0d_tx", it), 64'(txq[0]), 64'(b));
      txq.delete(); txt.delete();
      repeat (2 * bitlen) @(negedge clk);
    end
    bus_read(8'h01, s);
    check("rand_final_status", 64'(s), 64'({4'b0000, m_ferr, m_ovr, m_valid, 2'b00}));
    bus_read(8'h00, s);
    check("rand_final_data", 64'(s), 64'(m_data));

    // Reset in the middle of a TX frame acts without a clock edge.
    set_div(16'd3);
    bus_write(8'h00, 8'hF0);
    repeat (10) @(negedge clk);
    addr = 8'h01;
    #1 check("midtx_busy_before", 64'(dout[0]), 64'(1));
    reset = 1'b1;
    #1;
    check("midtx_reset_tx", 64'(tx), 64'(1));
    check("midtx_reset_status", 64'(dout), 64'h00);
    @(negedge clk);
    reset = 1'b0;
    bus_read(8'h02, s); check("midtx_divl", 64'(s), 64'h63);
    bus_read(8'h03, s); check("midtx_divh", 64'(s), 64'h03);
    bus_read(8'h00, s); check("midtx_rxdata", 64'(s), 64'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_top.md
UART_TOP -- requirements
Module: uart_top

Interface
REQ-001 Parameter ADDR_LSB, default 0, LSB of addr used for register select.
REQ-002 Parameter OPT_MEM_ADDR_BITS, default 1, register-select width minus one; selector is addr[ADDR_LSB+OPT_MEM_ADDR_BITS:ADDR_LSB].
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 addr  input  8  CPU bus address; decode to this block done externally.
REQ-006 din  input  8  CPU write data.
REQ-007 dout  output  8  CPU read data, combinational from selector.
REQ-008 wr_en  input  1  write strobe, one cycle per access.
REQ-009 rd_en  input  1  read strobe, one cycle per access.
REQ-010 tx  output  1  serial transmit, idle high.
REQ-011 rx  input  1  serial receive, asynchronous to clk.

Function
REQ-012 Register map by selector: 0 = TXDATA (W) / RXDATA (R); 1 = STATUS (R); 2 = DIVL (R/W); 3 = DIVH (R/W).
REQ-013 STATUS bits: [0] tx_busy, [1] tx_full, [2] rx_valid, [3] rx_overrun, [4] rx_frame_err, [5] rx_parity_err, [7:6] read 0.
REQ-014 Bit period = {DIVH,DIVL}+1 clocks; divisor value 0 gives 1 clock per bit; divisor writes take effect at the next bit boundary.
REQ-015 Frame: start bit 0, 8 data bits LSB first, optional parity (REQ-031), one stop bit 1.
REQ-016 TX path: one-deep holding register plus shift register; write to TXDATA with tx_full=0 loads holding and sets tx_full next cycle.
REQ-017 Write to TXDATA with tx_full=1 is ignored, even if the shifter loads holding in that same cycle.
REQ-018 TX FSM states IDLE, START, DATA, STOP (PARITY with macro); IDLE->START the cycle after tx_full=1, clearing tx_full; STOP->START directly if tx_full=1, else IDLE.
REQ-019 tx_busy = 1 in every TX state except IDLE; tx = 1 in IDLE.
REQ-020 RX input passes through a 2-flop synchronizer before use (2-cycle detection latency).
REQ-021 RX FSM states IDLE, START, DATA, STOP (PARITY with macro); falling edge of synchronized rx in IDLE -> START.
REQ-022 START samples at (divisor+1)/2 clocks; rx high there -> glitch, return to IDLE, no flags changed.
REQ-023 DATA/PARITY/STOP bits each sampled one bit period after the previous sample.
REQ-024 At STOP sample: stop=0 sets rx_frame_err; byte is still stored per REQ-025/026.
REQ-025 Completed byte with rx_valid=0: written to RXDATA, rx_valid set.
REQ-026 Completed byte with rx_valid=1: byte discarded, RXDATA unchanged, rx_overrun set.
REQ-027 rd_en on selector 0 clears rx_valid; if a byte completes in the same cycle it is stored and rx_valid stays 1 (no overrun).
REQ-028 rd_en on selector 1 clears bits 3-5 after returning them; a same-cycle set event wins.
REQ-029 wr_en to read-only selector 1 is ignored; rd_en has no side effect on selectors 2-3.

Reset
REQ-030 On reset asserted: tx=1, both FSMs IDLE, tx_full=0, all STATUS flags 0, RXDATA=0x00, holding/shift registers 0, divisor=16'd867, synchronizer flops=1; effective immediately, mid-frame included.

Configuration
REQ-031 Macro UART_PARITY_EN defined: even parity bit after data on TX; on RX parity mismatch sets rx_parity_err (byte still stored).
REQ-032 UART_PARITY_EN undefined: 8N1 frame, no PARITY states, STATUS[5] constant 0.

Verification
REQ-033 Divisor=3, write 0x55 to TXDATA -> tx shows 0,1,0,1,0,1,0,1,0,1 each held 4 clocks, tx_busy high 40 clocks, then idle high.
REQ-034 Divisor=3, two back-to-back TXDATA writes 0xA5, 0x3C then a third while tx_full=1 -> only A5 and 3C framed with no idle gap; third ignored.
REQ-035 Drive rx frame 0xC3 at divisor=7 -> rx_valid=1, RXDATA=0xC3; rd_en sel 0 -> rx_valid=0.
REQ-036 Two rx frames 0x11, 0x22 without reading -> RXDATA=0x11, rx_overrun=1; STATUS read returns 0x0C, then reads 0x04.
REQ-037 rx frame 0x7E with stop bit 0 -> RXDATA=0x7E, rx_frame_err=1; 1-clock low glitch on rx -> no flag, FSM IDLE.
REQ-038 reset asserted mid-TX frame -> tx=1 and tx_busy=0 without clock edge; divisor reads 0x63 (DIVL), 0x03 (DIVH).
